yuv_to_rgb_stream: RTL and testbench

//  Streaming, parametrised YUV->RGB colour-space converter: one 4:4:4 pixel in per cycle, one RGB pixel out per cycle.

---
 rtl/yuv_to_rgb_stream_if.sv | 29 ++
 rtl/yuv_to_rgb_stream.sv | 177 +++++++++++++++++
 tb/tb_yuv_to_rgb_stream.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/yuv_to_rgb_stream_if.sv
// Pixel stream bundle for yuv_to_rgb_stream: YUV input side, RGB output side and frame status.
interface yuv_to_rgb_stream_if #(
  parameter int unsigned DW = 8
);
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_y;
  logic [DW-1:0] in_u;
  logic [DW-1:0] in_v;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_g;
  logic [DW-1:0] out_b;
  logic          out_sof;
  logic          out_eol;
  logic          frame_done;

  modport master (
    output mode, in_valid, in_y, in_u, in_v, out_ready,
    input  in_ready, out_valid, out_r, out_g, out_b, out_sof, out_eol, frame_done
  );

  modport slave (
    input  mode, in_valid, in_y, in_u, in_v, out_ready,
    output in_ready, out_valid, out_r, out_g, out_b, out_sof, out_eol, frame_done
  );
endinterface

// File: rtl/yuv_to_rgb_stream.sv
// Streaming YUV 4:4:4 -> RGB converter: 3-stage pipeline, BT.601/BT.709 chosen per pixel,
// rounded and saturated outputs, SOF/EOL/frame_done derived from a W x H output position.
module yuv_to_rgb_stream #(
  parameter int unsigned DW   = 8,
  parameter int unsigned FRAC = 16,
  parameter int unsigned W    = 320,
  parameter int unsigned H    = 240
) (
  input logic                clk,
  input logic                rst,
  yuv_to_rgb_stream_if.slave bus
);
  localparam int unsigned IW = DW + 2;
  localparam int unsigned CW = FRAC + 3;
  localparam int unsigned PW = CW + IW;
  localparam int unsigned SW = PW + 2;
  localparam int unsigned XW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned YW = (H > 1) ? $clog2(H) : 1;

  // Coefficient table is written in Q.16; rescale to the configured FRAC.
  function automatic longint scale(input longint k);
    if (FRAC >= 16) return k <<< (FRAC - 16);
    return k >>> (16 - FRAC);
  endfunction

  localparam logic signed [CW-1:0] KY    = CW'(scale(64'sd76284));
  localparam logic signed [CW-1:0] RV601 = CW'(scale(64'sd104595));
  localparam logic signed [CW-1:0] GU601 = CW'(scale(-64'sd25624));
  localparam logic signed [CW-1:0] GV601 = CW'(scale(-64'sd53281));
  localparam logic signed [CW-1:0] BU601 = CW'(scale(64'sd132251));
  localparam logic signed [CW-1:0] RV709 = CW'(scale(64'sd117489));
  localparam logic signed [CW-1:0] GU709 = CW'(scale(-64'sd13975));
  localparam logic signed [CW-1:0] GV709 = CW'(scale(-64'sd34925));
  localparam logic signed [CW-1:0] BU709 = CW'(scale(64'sd138438));

  localparam logic signed [IW-1:0] YOFF = IW'(16 << (DW - 8));
  localparam logic signed [IW-1:0] COFF = IW'(1 << (DW - 1));
  localparam logic signed [SW-1:0] RND  = SW'(longint'(1) << (FRAC - 1));

  function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] s);
    if (s[SW-1]) return '0;
    if (|s[SW-2:DW+FRAC]) return '1;
    return s[FRAC+DW-1:FRAC];
  endfunction

  logic en;
  logic out_xfer;

  // Stage 1: offset removal
  logic                 s1_valid;
  logic                 s1_mode;
  logic signed [IW-1:0] s1_ys;
  logic signed [IW-1:0] s1_us;
  logic signed [IW-1:0] s1_vs;

  // Stage 2: full-width products
  logic                 s2_valid;
  logic signed [PW-1:0] s2_py;
  logic signed [PW-1:0] s2_prv;
  logic signed [PW-1:0] s2_pgu;
  logic signed [PW-1:0] s2_pgv;
  logic signed [PW-1:0] s2_pbu;

  // Stage 3: output registers
  logic          out_valid_q;
  logic [DW-1:0] out_r_q;
  logic [DW-1:0] out_g_q;
  logic [DW-1:0] out_b_q;

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          frame_done_q;
  logic          last_x;
  logic          last_y;

  logic signed [CW-1:0] rv_c;
  logic signed [CW-1:0] gu_c;
  logic signed [CW-1:0] gv_c;
  logic signed [CW-1:0] bu_c;
  logic signed [SW-1:0] sum_r;
  logic signed [SW-1:0] sum_g;
  logic signed [SW-1:0] sum_b;

  // A stalled output register freezes the whole pipe, bubbles included.
  assign en       = !out_valid_q || bus.out_ready;
  assign out_xfer = out_valid_q && bus.out_ready;
  assign last_x   = (x_q == XW'(W - 1));
  assign last_y   = (y_q == YW'(H - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_ys    <= '0;
      s1_us    <= '0;
      s1_vs    <= '0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s1_mode  <= bus.mode;
      s1_ys    <= $signed({2'b00, bus.in_y}) - YOFF;
      s1_us    <= $signed({2'b00, bus.in_u}) - COFF;
      s1_vs    <= $signed({2'b00, bus.in_v}) - COFF;
    end
  end

  always_comb begin
    rv_c = s1_mode ? RV709 : RV601;
    gu_c = s1_mode ? GU709 : GU601;
    gv_c = s1_mode ? GV709 : GV601;
    bu_c = s1_mode ? BU709 : BU601;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_py    <= '0;
      s2_prv   <= '0;
      s2_pgu   <= '0;
      s2_pgv   <= '0;
      s2_pbu   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_py    <= PW'(s1_ys) * PW'(KY);
      s2_prv   <= PW'(s1_vs) * PW'(rv_c);
      s2_pgu   <= PW'(s1_us) * PW'(gu_c);
      s2_pgv   <= PW'(s1_vs) * PW'(gv_c);
      s2_pbu   <= PW'(s1_us) * PW'(bu_c);
    end
  end

  always_comb begin
    sum_r = SW'(s2_py) + SW'(s2_prv) + RND;
    sum_g = SW'(s2_py) + SW'(s2_pgu) + SW'(s2_pgv) + RND;
    sum_b = SW'(s2_py) + SW'(s2_pbu) + RND;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_g_q     <= '0;
      out_b_q     <= '0;
    end else if (en) begin
      out_valid_q <= s2_valid;
      out_r_q     <= sat(sum_r);
      out_g_q     <= sat(sum_g);
      out_b_q     <= sat(sum_b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= out_xfer && last_x && last_y;
      if (out_xfer) begin
        if (last_x) begin
          x_q <= '0;
          y_q <= last_y ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready   = en;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_r      = out_r_q;
  assign bus.out_g      = out_g_q;
  assign bus.out_b      = out_b_q;
  assign bus.out_sof    = out_valid_q && (x_q == '0) && (y_q == '0);
  assign bus.out_eol    = out_valid_q && last_x;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_yuv_to_rgb_stream.sv
// Bench for yuv_to_rgb_stream: directed table, pipeline timing/stall/reset sequences and a
// randomized stream scored against an arithmetic colour model with frame-position tracking.
module tb_yuv_to_rgb_stream;
  localparam int unsigned W  = 320;
  localparam int unsigned H  = 240;
  localparam int unsigned FR = W * H;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct {
    int y;
    int u;
    int v;
    bit m;
    int r;
    int g;
    int b;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  yuv_to_rgb_stream_if #(.DW(8)) bus ();

  yuv_to_rgb_stream #(.DW(8), .FRAC(16), .W(W), .H(H)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          total = 0;
  int          bad   = 0;
  rgb_t        exp_q[$];
  int unsigned pos_idx = 0;
  bit          fd_exp  = 1'b0;
  int          sof_seen = 0;
  int          eol_seen = 0;
  int          fd_seen  = 0;
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] clamp8(input longint s);
    if (s < 0) return 8'd0;
    if (s >= (longint'(1) << 24)) return 8'd255;
    return 8'(s >> 16);
  endfunction

  // Plain BT.601/BT.709 integer arithmetic with Q16 coefficients and round-half-up.
  function automatic rgb_t model(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v,
                                 input logic m);
    longint ys, us, vs, yp, rv, gu, gv, bu;
    rgb_t   res;
    ys = longint'(y) - 16;
    us = longint'(u) - 128;
    vs = longint'(v) - 128;
    if (m) begin
      rv = 117489; gu = -13975; gv = -34925; bu = 138438;
    end else begin
      rv = 104595; gu = -25624; gv = -53281; bu = 132251;
    end
    yp    = 76284 * ys;
    res.r = clamp8(yp + rv * vs + 32768);
    res.g = clamp8(yp + gu * us + gv * vs + 32768);
    res.b = clamp8(yp + bu * us + 32768);
    return res;
  endfunction

  // Scoreboard: every accepted pixel is queued; every valid output is compared to the head.
  always @(negedge clk) begin
    rgb_t e;
    if (rst) begin
      exp_q.delete();
      pos_idx = 0;
      fd_exp  = 1'b0;
    end else begin
      chk("frame_done", bus.frame_done, fd_exp);
      if (bus.frame_done) fd_seen++;
      fd_exp = 1'b0;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_qsize", exp_q.size(), 1);
        end else begin
          e = exp_q[0];
          chk("out_r", bus.out_r, e.r);
          chk("out_g", bus.out_g, e.g);
          chk("out_b", bus.out_b, e.b);
          chk("out_sof", bus.out_sof, (pos_idx % FR) == 0);
          chk("out_eol", bus.out_eol, (pos_idx % W) == W - 1);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            if (bus.out_sof) sof_seen++;
            if (bus.out_eol) eol_seen++;
            if ((pos_idx % FR) == FR - 1) fd_exp = 1'b1;
            pos_idx++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_y, bus.in_u, bus.in_v, bus.mode));
    end
  end

  task automatic rand_pix();
    bus.in_y = 8'($urandom);
    bus.in_u = 8'($urandom);
    bus.in_v = 8'($urandom);
    bus.mode = 1'($urandom);
  endtask

  // Drives n pixels with given valid/ready percentages; out_ready is forced low in [s0,s1).
  task automatic run_stream(input int n, input int vpct, input int rpct, input int s0,
                            input int s1);
    int   sent = 0;
    int   c    = 0;
    logic fire = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (fire) sent++;
      if (sent >= n || c >= n * 20 + 100) break;
      if (!bus.in_valid || fire) begin
        if (int'($urandom % 100) < vpct) begin
          bus.in_valid = 1'b1;
          rand_pix();
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = (c >= s0 && c < s1) ? 1'b0 : (int'($urandom % 100) < rpct);
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      if (c >= s0 && c < s1) begin
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
      end
      c++;
    end
    bus.in_valid = 1'b0;
    chk("stream_sent", sent, n);
  endtask

  task automatic drain();
    int k = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("drain_qsize", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   first;
    logic got;

    tbl[0] = '{y: 235, u: 128, v: 128, m: 0, r: 255, g: 255, b: 255};
    tbl[1] = '{y: 16,  u: 128, v: 128, m: 0, r: 0,   g: 0,   b: 0};
    tbl[2] = '{y: 126, u: 128, v: 128, m: 0, r: 128, g: 128, b: 128};
    tbl[3] = '{y: 81,  u: 90,  v: 240, m: 0, r: 254, g: 0,   b: 0};
    tbl[4] = '{y: 81,  u: 90,  v: 240, m: 1, r: 255, g: 24,  b: 0};
    tbl[5] = '{y: 255, u: 255, v: 255, m: 0, r: 255, g: 125, b: 255};
    tbl[6] = '{y: 0,   u: 0,   v: 0,   m: 0, r: 0,   g: 135, b: 0};
    tbl[7] = '{y: 126, u: 128, v: 128, m: 1, r: 128, g: 128, b: 128};

    bus.in_valid  = 1'b0;
    bus.in_y      = '0;
    bus.in_u      = '0;
    bus.in_v      = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_r", bus.out_r, 0);
    chk("rst_out_g", bus.out_g, 0);
    chk("rst_out_b", bus.out_b, 0);
    chk("rst_sof", bus.out_sof, 0);
    chk("rst_eol", bus.out_eol, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_y     = 8'(tbl[i].y);
      bus.in_u     = 8'(tbl[i].u);
      bus.in_v     = 8'(tbl[i].v);
      bus.mode     = tbl[i].m;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (bus.out_valid) got = 1'b1;
      end
      chk("tbl_out_seen", got, 1);
      if (got) begin
        chk("tbl_r", bus.out_r, tbl[i].r);
        chk("tbl_g", bus.out_g, tbl[i].g);
        chk("tbl_b", bus.out_b, tbl[i].b);
      end
    end

    // Latency and throughput: 8 back-to-back pixels
    first = -1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin
        bus.in_valid = 1'b1;
        rand_pix();
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 8) chk("thru_in_ready", bus.in_ready, 1);
      chk("thru_out_valid", bus.out_valid, (c >= 3 && c <= 10));
      if (bus.out_valid && first < 0) first = c;
    end
    chk("latency", first, 3);

    // Five-cycle downstream stall mid-stream
    run_stream(12, 100, 100, 5, 10);
    drain();

    // Randomized valid/ready traffic
    run_stream(300, 70, 60, -1, -1);
    drain();
    run_stream(200, 95, 90, -1, -1);
    drain();

    // Reset with two pixels in flight
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    rand_pix();
    @(posedge clk); #1;
    rand_pix();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_out_valid", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_out_valid", bus.out_valid, 0);
    chk("rst_async_out_r", bus.out_r, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_no_stale", bus.out_valid, 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    rand_pix();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    chk("post_rst_out_seen", got, 1);
    chk("post_rst_sof", bus.out_sof, 1);
    drain();

    // Full frame plus the start of the next one
    do_reset();
    sof_seen = 0;
    eol_seen = 0;
    fd_seen  = 0;
    run_stream(FR + 5, 100, 100, -1, -1);
    drain();
    @(negedge clk);
    chk("frame_sof_count", sof_seen, 2);
    chk("frame_eol_count", eol_seen, H);
    chk("frame_done_count", fd_seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
